// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a byte stream (header N, then 4*N little-endian payload bytes).
// Issues one word write per 4 bytes at byte addresses 0, 4, 8, ...
// The core is held in reset until the whole program is in memory.
module imem_loader #(
  parameter int MAX_WORDS = 22,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Header limit in the header's own width, so the comparison is unsigned 8-bit.
  localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t            state_q;
  logic [7:0]        count_q;
  logic [7:0]        word_idx_q;
  logic [1:0]        byte_idx_q;
  logic              in_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;

  // A byte is consumed only when the registered ready is high.
  logic xfer;
  assign xfer = in_valid && in_ready_q;

  // Load sequencer; every output is a register updated with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      word_idx_q <= 8'd0;
      byte_idx_q <= 2'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // The strobe lasts exactly the one WRITE cycle.
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= HDR;
            in_ready_q <= 1'b1;
          end
        end
        HDR: begin
          // start is deliberately not looked at here.
          if (xfer) begin
            count_q <= in_data;
            if (in_data == 8'd0) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else if (in_data > MAX_W8) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q    <= DATA;
              byte_idx_q <= 2'd0;
              word_idx_q <= 8'd0;
            end
          end
        end
        DATA: begin
          // Bytes land directly in the output word, LSB first; bubbles hold everything.
          if (xfer) begin
            wdata_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              we_q       <= 1'b1;
              waddr_q    <= ADDR_W'({word_idx_q, 2'b00});
            end
          end
        end
        WRITE: begin
          if (word_idx_q == count_q - 8'd1) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= DATA;
            word_idx_q <= word_idx_q + 8'd1;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_q    <= HDR;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        end
        ERR: begin
          if (start) begin
            state_q    <= HDR;
            in_ready_q <= 1'b1;
            error_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams, captures every write strobe
// and compares against hand-computed words and addresses.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors;
  int checks;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic        prev_we;
  logic [31:0] exp_words[22];

  imem_loader #(.MAX_WORDS(22), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write capture and back-to-back strobe check, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && we) begin
      cap_addr.push_back(waddr);
      cap_data.push_back(wdata);
      $display("write: waddr=%0d wdata=%h", waddr, wdata);
      check("we_gap", {31'd0, prev_we}, 32'd0);
    end
    prev_we <= rst_n ? we : 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and wait (bounded) for its transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent;
    sent = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (in_ready) sent = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!sent) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: byte %h never accepted (observed in_ready=0, required 1)", b);
    end
    $display("byte %h sent=%0d", b, sent);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
  endtask

  function automatic logic [31:0] cap_a(input int k);
    return (k < cap_addr.size()) ? cap_addr[k] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] cap_d(input int k);
    return (k < cap_data.size()) ? cap_data[k] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    prev_we  = 1'b0;

    // Reset values.
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",       {31'd0, we},       32'd0);
    check("rst_waddr",    waddr,             32'd0);
    check("rst_wdata",    wdata,             32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);

    // Two-word load.
    clear_cap();
    pulse_start();
    check("hdr_in_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h02, 0);
    send_word(32'h0003A103, 0);
    check("w0_we_now",  {31'd0, we}, 32'd1);
    check("w0_waddr",   waddr, 32'd0);
    check("w0_ready",   {31'd0, in_ready}, 32'd0);
    send_word(32'h00010433, 0);
    check("w1_waddr",   waddr, 32'd4);
    check("w1_wdata",   wdata, 32'h00010433);
    check("w1_hold",    {31'd0, cpu_hold}, 32'd1);
    tick();
    check("two_done",   {31'd0, done}, 32'd1);
    check("two_hold",   {31'd0, cpu_hold}, 32'd0);
    check("two_we_off", {31'd0, we}, 32'd0);
    check("two_count",  cap_addr.size(), 32'd2);
    check("two_a0",     cap_a(0), 32'd0);
    check("two_d0",     cap_d(0), 32'h0003A103);
    check("two_a1",     cap_a(1), 32'd4);
    check("two_d1",     cap_d(1), 32'h00010433);

    // Reload from DONE raises hold; empty program completes right away.
    clear_cap();
    pulse_start();
    check("restart_hold", {31'd0, cpu_hold}, 32'd1);
    check("restart_done", {31'd0, done}, 32'd0);
    send_byte(8'h00, 0);
    check("empty_done",  {31'd0, done}, 32'd1);
    check("empty_hold",  {31'd0, cpu_hold}, 32'd0);
    check("empty_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("empty_no_we", cap_addr.size(), 32'd0);

    // Oversize header: 23 words against a limit of 22.
    pulse_start();
    send_byte(8'd23, 0);
    check("ovr_error", {31'd0, error}, 32'd1);
    check("ovr_ready", {31'd0, in_ready}, 32'd0);
    check("ovr_hold",  {31'd0, cpu_hold}, 32'd1);
    check("ovr_done",  {31'd0, done}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    check("ovr_sticky", {31'd0, error}, 32'd1);
    check("ovr_ready2", {31'd0, in_ready}, 32'd0);
    check("ovr_no_we",  cap_addr.size(), 32'd0);
    pulse_start();
    check("ovr_clear",  {31'd0, error}, 32'd0);
    check("ovr_hdr",    {31'd0, in_ready}, 32'd1);

    // Full 22-word program with random bubbles (already in HDR).
    clear_cap();
    for (int k = 0; k < 22; k++) exp_words[k] = $urandom();
    send_byte(8'h16, $urandom_range(0, 3));
    for (int k = 0; k < 22; k++) send_word(exp_words[k], $urandom_range(0, 3));
    check("full_last_addr", waddr, 32'd84);
    check("full_last_hold", {31'd0, cpu_hold}, 32'd1);
    tick();
    check("full_done",  {31'd0, done}, 32'd1);
    check("full_count", cap_addr.size(), 32'd22);
    for (int k = 0; k < 22; k++) begin
      check($sformatf("full_a%0d", k), cap_a(k), 32'(4 * k));
      check($sformatf("full_d%0d", k), cap_d(k), exp_words[k]);
    end

    // Reset in the middle of a word.
    clear_cap();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_wdata", wdata, 32'd0);
    check("mid_rst_waddr", waddr, 32'd0);
    check("mid_rst_hold",  {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_done",  {31'd0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    check("mid_idle_ready", {31'd0, in_ready}, 32'd0);
    check("mid_no_we",      cap_addr.size(), 32'd0);
    check("mid_done",       {31'd0, done}, 32'd0);

    // Reload after a completed 1-word load.
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'h12345678, 0);
    tick();
    check("one_done", {31'd0, done}, 32'd1);
    clear_cap();
    pulse_start();
    check("reload_hold", {31'd0, cpu_hold}, 32'd1);
    check("reload_done", {31'd0, done}, 32'd0);
    send_byte(8'h01, 1);
    send_word(32'h01400B13, 1);
    tick();
    check("reload_count", cap_addr.size(), 32'd1);
    check("reload_a0",    cap_a(0), 32'd0);
    check("reload_d0",    cap_d(0), 32'h01400B13);
    check("reload_fin",   {31'd0, done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word at byte addresses 0, 4, 8, … (the instruction memory is indexed by byte address, with words at multiples of 4). While loading, it holds the pipelined core in reset. It releases the core only after the full program has been written.

## Interface

Parameters:
- MAX_WORDS, 22: maximum program length in words. The highest write address is 4*(MAX_WORDS-1), which is 84 at the default.
- ADDR_W, 32: width of waddr.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that arms a new load.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a transfer occurs when in_valid && in_ready are high at a rising edge.
- we  out  1  instruction-memory write strobe, one cycle per word.
- waddr  out  ADDR_W  write byte address.
- wdata  out  32  write data.
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  load completed.
- error  out  1  header rejected; sticky until the next start.

## Operation

- Stream format: one header byte N (the word count), followed by 4*N payload bytes. Each word arrives LSB byte first.
- The FSM is Moore, and all outputs are decoded from registered state or registers. States:
  - IDLE:
    - in_ready=0, cpu_hold=1.
    - start → HDR.
  - HDR:
    - in_ready=1.
    - On a transfer, latch count=in_data, then:
      - in_data==0 → DONE.
      - in_data>MAX_WORDS → ERR.
      - otherwise → DATA, with byte_idx=0 and word_idx=0.
  - DATA:
    - in_ready=1.
    - On each transfer, write in_data into wdata[8*byte_idx +: 8] and increment byte_idx.
    - The transfer with byte_idx==3 moves to WRITE, with byte_idx wrapping to 0.
  - WRITE:
    - in_ready=0, we=1, waddr={word_idx,2'b00}, wdata holds the assembled word.
    - Next state: word_idx==count-1 → DONE; otherwise word_idx+1 and → DATA.
  - DONE:
    - done=1, cpu_hold=0, in_ready=0.
    - start → HDR, with done=0 and cpu_hold=1 on the next cycle.
  - ERR:
    - error=1, cpu_hold=1, in_ready=0.
    - start → HDR, with error cleared.
- Width rules:
  - word_idx is 8 bits and is zero-extended and shifted left by 2 to form waddr.
  - count is compared unsigned.
- The block writes no address at or above 4*count, and it never reads memory.

## Timing

- Reset values (asynchronous, applied immediately on rst_n low):
  - state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, error=0.
  - byte_idx, word_idx and count are all 0.
- Latency:
  - The 4th byte of a word transfers at edge t; we is high during cycle t+1.
  - The next byte can transfer at edge t+2 at the earliest.
  - Peak throughput is 1 word per 5 cycles.
- After the final write, done=1 and cpu_hold=0 in the cycle following the WRITE cycle.
- in_valid may drop between any bytes. Bubbles stall the FSM with no state change, and partially assembled bytes are kept.
- in_valid while in_ready=0 is ignored; no byte is consumed.
- start is ignored in HDR, DATA and WRITE.
- start coincident with a transfer in HDR is also ignored; the transfer proceeds normally.
- rst_n low mid-word or mid-program:
  - The partial word is discarded and no write is issued.
  - The block returns to IDLE with all reset values, including cpu_hold=1.
  - Previously written words remain in memory, but done stays 0.
- we is never high for two consecutive cycles. waddr and wdata are stable for the whole we cycle.

## Test plan

- **Two-word load.** start, then bytes 02, 03 A1 03 00, 33 04 01 00.
  - Expect we at waddr=0 with wdata=0x0003A103.
  - Expect we at waddr=4 with wdata=0x00010433.
  - Then done=1, cpu_hold=0, exactly 2 we pulses.
- **Empty program.** start, header 00 → DONE within 1 cycle of the transfer; no we pulses; cpu_hold=0.
- **Oversize header.** start, header 23 (MAX_WORDS=22).
  - Expect error=1, in_ready=0, cpu_hold=1, no we; following in_valid bytes are not consumed.
  - A subsequent start → error=0, in_ready=1 (HDR).
- **Full program with throttling.** Header 22 (0x16) and 88 payload bytes, with random 0–3 cycle in_valid gaps.
  - Expect 22 we pulses at waddr 0, 4, …, 84, with data matching the stream.
  - The last write is at waddr=84; done follows.
- **Reset mid-word.** Header 01, then bytes 13 00 40 (3 bytes), then rst_n pulsed low.
  - Expect an immediate return to the reset values, no we ever, and in_ready=0 until the next start.
- **Reload after done.** Completed 1-word load, then start → cpu_hold=1, done=0.
  - A new 1-word stream 13 0B 40 01 writes waddr=0 with wdata=0x01400B13.
